// File: rtl/merge_pipe_r_if.sv
// Load/merge bus for merge_pipe_r: half loads with ready back-pressure,
// merged result with valid/ready, completed-merge counter.
interface merge_pipe_r_if #(
  parameter int WIDTH = 3,
  parameter int n     = 4,
  parameter int CNT_W = 16
);
  logic [1:0]           load;
  logic [1:0]           ready;
  logic [2*n*WIDTH-1:0] inba;
  logic                 desc;
  logic [2*n*WIDTH-1:0] c;
  logic                 out_valid;
  logic                 out_ready;
  logic [CNT_W-1:0]     merge_cnt;

  modport master (
    output load, inba, desc, out_ready,
    input  ready, c, out_valid, merge_cnt
  );

  modport slave (
    input  load, inba, desc, out_ready,
    output ready, c, out_valid, merge_cnt
  );
endinterface

// File: rtl/merge_pipe_r.sv
// Pipelined Batcher odd-even merger: two sorted n-key halves in, one sorted
// 2n-key vector out, one register per comparator layer, stall-on-backpressure.

module merge_pipe_r_cmp #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_dir,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_hi
);
  logic w_swap;

  // strict compare so equal keys keep their positions
  assign w_swap = i_dir ? (i_a < i_b) : (i_a > i_b);
  assign o_lo   = w_swap ? i_b : i_a;
  assign o_hi   = w_swap ? i_a : i_b;
endmodule

module merge_pipe_r #(
  parameter int WIDTH = 3,
  parameter int n     = 4,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  merge_pipe_r_if.slave bus
);
  localparam int N = 2 * n;
  localparam int S = $clog2(N);

  logic [N-1:0][WIDTH-1:0]      w_in;
  logic [n-1:0][WIDTH-1:0]      r_a_h, r_b_h;
  logic                         r_fa, r_fb, r_dir_h;
  logic                         w_adv, w_launch;
  logic [1:0]                   w_acc;

  // index 0 is the launch register; index s+1 holds the result of layer s
  logic [S:0][N-1:0][WIDTH-1:0] r_dat;
  logic [S:0]                   r_dir;
  logic [S:0]                   vld_pipe;
  logic [S-1:0][N-1:0][WIDTH-1:0] w_nxt;
  logic [CNT_W-1:0]             r_cnt;

  assign w_in      = bus.inba;
  assign w_adv     = ~vld_pipe[S] | bus.out_ready;
  assign w_launch  = r_fa & r_fb & w_adv;
  assign bus.ready = {~r_fb | w_launch, ~r_fa | w_launch};
  assign w_acc     = bus.load & bus.ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fa    <= 1'b0;
      r_fb    <= 1'b0;
      r_dir_h <= 1'b0;
      r_a_h   <= '0;
      r_b_h   <= '0;
    end else begin
      // a reload in the launch cycle wins over the launch clear
      if (w_acc[0]) begin
        r_a_h <= w_in[n-1:0];
        r_fa  <= 1'b1;
      end else if (w_launch) begin
        r_fa  <= 1'b0;
      end
      if (w_acc[1]) begin
        r_b_h   <= w_in[N-1:n];
        r_dir_h <= bus.desc;
        r_fb    <= 1'b1;
      end else if (w_launch) begin
        r_fb    <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      r_dat    <= '0;
      r_dir    <= '0;
    end else if (w_adv) begin
      vld_pipe <= {vld_pipe[S-1:0], w_launch};
      r_dat[0] <= {r_b_h, r_a_h};
      r_dir[0] <= r_dir_h;
      for (int s = 0; s < S; s++) begin
        r_dat[s+1] <= w_nxt[s];
        r_dir[s+1] <= r_dir[s];
      end
    end
  end

  // Layer s compares distance K = n>>s. The first layer pairs i with i+n;
  // later layers pair each element of an odd K-block with the next block,
  // leaving the first and last K elements untouched.
  for (genvar s = 0; s < S; s++) begin : g_stg
    localparam int K = n >> s;
    for (genvar e = 0; e < N; e++) begin : g_el
      localparam bit LO = (K == n) ? (e < n)  : (((e / K) % 2 == 1) && (e + K < N));
      localparam bit HI = (K == n) ? (e >= n) : (((e / K) % 2 == 0) && (e >= K));
      if (LO) begin : g_cmp
        merge_pipe_r_cmp #(.WIDTH(WIDTH)) u_cmp (
          .i_a   (r_dat[s][e]),
          .i_b   (r_dat[s][e+K]),
          .i_dir (r_dir[s]),
          .o_lo  (w_nxt[s][e]),
          .o_hi  (w_nxt[s][e+K])
        );
      end else if (!HI) begin : g_pass
        assign w_nxt[s][e] = r_dat[s][e];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                               r_cnt <= '0;
    else if (vld_pipe[S] && bus.out_ready)  r_cnt <= r_cnt + CNT_W'(1);
  end

  assign bus.c         = r_dat[S];
  assign bus.out_valid = vld_pipe[S];
  assign bus.merge_cnt = r_cnt;
endmodule

// File: tb/tb_merge_pipe_r.sv
// Directed bench for merge_pipe_r: 4+4x3b instance plus an 8+8x8b instance
// with a 2-bit counter for wrap and wider-network coverage.
module tb_merge_pipe_r;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  merge_pipe_r_if #(.WIDTH(3), .n(4), .CNT_W(16)) bus1();
  merge_pipe_r_if #(.WIDTH(8), .n(8), .CNT_W(2))  bus2();

  merge_pipe_r #(.WIDTH(3), .n(4), .CNT_W(16)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  merge_pipe_r #(.WIDTH(8), .n(8), .CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] v8(input logic [2:0] e0, e1, e2, e3, e4, e5, e6, e7);
    return {e7, e6, e5, e4, e3, e2, e1, e0};
  endfunction

  function automatic logic [127:0] p16(input int unsigned e[16]);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = e[i][7:0];
    return r;
  endfunction

  int cnt1 = 0;

  task automatic run1(input string tag, input logic [23:0] v, input logic d, input logic [23:0] exp);
    int lat;
    bus1.inba = v; bus1.desc = d; bus1.load = 2'b11; bus1.out_ready = 1'b1;
    tick();
    bus1.load = 2'b00;
    lat = 0;
    while (!bus1.out_valid && lat < 20) begin tick(); lat++; end
    chk({tag, "_lat"}, 128'(lat), 128'd4);
    chk({tag, "_c"}, 128'(bus1.c), 128'(exp));
    tick();
    cnt1++;
    chk({tag, "_cnt"}, 128'(bus1.merge_cnt), 128'(cnt1));
  endtask

  task automatic run2(input string tag, input logic [127:0] v, input logic d, input logic [127:0] exp);
    int lat;
    bus2.inba = v; bus2.desc = d; bus2.load = 2'b11; bus2.out_ready = 1'b1;
    tick();
    bus2.load = 2'b00;
    lat = 0;
    while (!bus2.out_valid && lat < 20) begin tick(); lat++; end
    chk({tag, "_lat"}, 128'(lat), 128'd5);
    chk({tag, "_c"}, bus2.c, exp);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0]  sv[5];
    logic [23:0]  se[5];
    logic [23:0]  held;
    logic [127:0] va, ea, vd, ed;
    int unsigned  t[16];
    int           li, oi, cyc;
    bit           stalled, saw0, ghost;

    bus1.load = 2'b00; bus1.inba = '0; bus1.desc = 1'b0; bus1.out_ready = 1'b0;
    bus2.load = 2'b00; bus2.inba = '0; bus2.desc = 1'b0; bus2.out_ready = 1'b0;

    #12;
    chk("rst_valid", 128'(bus1.out_valid), 128'd0);
    chk("rst_cnt",   128'(bus1.merge_cnt), 128'd0);
    chk("rst_c",     128'(bus1.c),         128'd0);
    chk("rst_ready", 128'(bus1.ready),     128'd3);
    rst = 1'b1;
    tick();

    run1("asc",  v8(1,3,5,7, 0,2,4,6), 1'b0, v8(0,1,2,3,4,5,6,7));
    run1("desc", v8(7,5,3,1, 6,4,2,0), 1'b1, v8(7,6,5,4,3,2,1,0));
    run1("dups", v8(2,2,5,5, 2,3,5,7), 1'b0, v8(2,2,2,3,5,5,5,7));

    // split load: A on cycle 0, ignored A reload on cycle 2, B on cycle 3
    bus1.load = 2'b01; bus1.inba = v8(0,4,4,6, 0,0,0,0); bus1.desc = 1'b0;
    tick();
    bus1.load = 2'b00; #1;
    chk("split_rdy_c1", 128'(bus1.ready), 128'd2);
    tick();
    bus1.load = 2'b01; bus1.inba = v8(7,7,7,7, 0,0,0,0); #1;
    chk("split_rdy_c2", 128'(bus1.ready), 128'd2);
    tick();
    bus1.load = 2'b10; bus1.inba = v8(0,0,0,0, 1,2,3,7); #1;
    chk("split_rdy_c3", 128'(bus1.ready), 128'd2);
    tick();
    bus1.load = 2'b00; #1;
    chk("split_rdy_c4", 128'(bus1.ready), 128'd3);
    li = 0;
    while (!bus1.out_valid && li < 20) begin tick(); li++; end
    chk("split_lat", 128'(li), 128'd4);
    chk("split_c", 128'(bus1.c), 128'(v8(0,1,2,3,4,4,6,7)));
    tick();
    cnt1++;

    // back-to-back stream with a 6-cycle output stall
    sv[0] = v8(0,1,2,3, 4,5,6,7); se[0] = v8(0,1,2,3,4,5,6,7);
    sv[1] = v8(1,1,1,1, 0,0,0,0); se[1] = v8(0,0,0,0,1,1,1,1);
    sv[2] = v8(3,3,6,6, 2,2,7,7); se[2] = v8(2,2,3,3,6,6,7,7);
    sv[3] = v8(0,0,0,7, 7,7,7,7); se[3] = v8(0,0,0,7,7,7,7,7);
    sv[4] = v8(5,6,6,7, 1,4,4,4); se[4] = v8(1,4,4,4,5,6,6,7);
    li = 0; oi = 0; cyc = 0; stalled = 0; saw0 = 0; held = '0;
    bus1.desc = 1'b0;
    while (oi < 5 && cyc < 60) begin
      bus1.out_ready = !(cyc >= 3 && cyc <= 8);
      if (li < 5) begin bus1.load = 2'b11; bus1.inba = sv[li]; end
      else bus1.load = 2'b00;
      #1;
      if (bus1.ready == 2'b00) saw0 = 1;
      if (stalled && bus1.out_valid) chk("stall_hold", 128'(bus1.c), 128'(held));
      stalled = bus1.out_valid && !bus1.out_ready;
      held    = bus1.c;
      if (bus1.out_valid && bus1.out_ready) begin
        chk("stream_c", 128'(bus1.c), 128'(se[oi]));
        oi++;
      end
      if (bus1.load == 2'b11 && bus1.ready == 2'b11) li++;
      tick();
      cyc++;
    end
    bus1.load = 2'b00;
    cnt1 += 5;
    chk("stream_out_n", 128'(oi), 128'd5);
    chk("stream_in_n",  128'(li), 128'd5);
    chk("stream_cnt",   128'(bus1.merge_cnt), 128'(cnt1));
    chk("stream_rdy0",  128'(saw0), 128'd1);

    // async reset with two merges in flight, head of pipe stalled at output
    bus1.out_ready = 1'b0; bus1.load = 2'b11; bus1.inba = sv[2];
    tick();
    bus1.inba = sv[4];
    tick();
    bus1.load = 2'b00;
    repeat (3) tick();
    chk("mid_valid", 128'(bus1.out_valid), 128'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_valid", 128'(bus1.out_valid), 128'd0);
    chk("mid_rst_cnt",   128'(bus1.merge_cnt), 128'd0);
    chk("mid_rst_c",     128'(bus1.c),         128'd0);
    tick();
    rst = 1'b1; bus1.out_ready = 1'b1;
    ghost = 0;
    repeat (10) begin tick(); if (bus1.out_valid) ghost = 1; end
    chk("post_rst_ghost", 128'(ghost), 128'd0);
    chk("post_rst_ready", 128'(bus1.ready), 128'd3);
    chk("post_rst_cnt",   128'(bus1.merge_cnt), 128'd0);

    // 8+8 x 8-bit instance, 2-bit counter
    t = '{200,150,100,90,50,40,10,0, 255,180,120,90,60,30,20,5};       vd = p16(t);
    t = '{255,200,180,150,120,100,90,90,60,50,40,30,20,10,5,0};        ed = p16(t);
    t = '{1,2,3,4,5,6,7,8, 0,0,9,9,9,10,11,255};                       va = p16(t);
    t = '{0,0,1,2,3,4,5,6,7,8,9,9,9,10,11,255};                        ea = p16(t);
    run2("w8_desc", vd, 1'b1, ed);
    run2("w8_asc",  va, 1'b0, ea);
    run2("w8_m3",   va, 1'b0, ea);
    run2("w8_m4",   vd, 1'b1, ed);
    chk("w8_cnt_wrap0", 128'(bus2.merge_cnt), 128'd0);
    run2("w8_m5",   va, 1'b0, ea);
    chk("w8_cnt_wrap1", 128'(bus2.merge_cnt), 128'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/merge_pipe_r.md
Name: merge_pipe_r

Overview:
- Parametrised, pipelined Batcher odd-even merger: takes two sorted n-element halves (A, B) of WIDTH-bit keys and produces one sorted 2n-element vector.
- Next generation of the fixed 4+4 merger. Adds generic n, per-half load with ready back-pressure, one register per comparator stage, output valid/ready handshake, per-merge ascending/descending mode and a completed-merge counter.
- Sits in the sorter datapath between the half-sorters and the V2V priority/scheduling logic.

Parameters:
WIDTH, 3, bits per key; compared unsigned, full width
n, 4, elements per half; power of 2, n >= 2
CNT_W, 16, width of merge_cnt

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
load  input  2  load[0] writes A half, load[1] writes B half; both may be asserted in the same cycle
ready  output  2  ready[k]=1 means a load[k] this cycle is accepted
inba  input  2*n*WIDTH  element i at [(i+1)*WIDTH-1:i*WIDTH]; A = elements 0..n-1, B = elements n..2n-1
desc  input  1  direction; sampled with an accepted load[1]
c  output  2*n*WIDTH  merged result; element 0 is first in sort order
out_valid  output  1  c holds a completed merge
out_ready  input  1  downstream accepts c
merge_cnt  output  CNT_W  number of completed output handshakes

Behaviour:
- Reset (rst=0, async): clear half-full flags, all stage valid bits, out_valid and merge_cnt. Force c to 0. ready becomes 2'b11 after reset releases.
- Capture stage:
  - Holding registers A_h, B_h with flags fa, fb; dir_h holds desc.
  - Accepted load[0] (load[0] & ready[0]) writes A_h from inba elements 0..n-1 and sets fa.
  - Accepted load[1] writes B_h from elements n..2n-1, sets fb, and latches desc into dir_h.
- Launch: occurs on a clock edge when fa & fb & adv. It moves {B_h, A_h, dir_h} into stage 1 and clears fa/fb, unless the same half is reloaded in that same cycle.
- ready[k] = ~f[k] | launch_this_cycle. This is combinational, and back-to-back reloads are allowed.
- Pipeline:
  - S = log2(2n) registered comparator stages implementing Batcher odd-even merge. For n=4, S=3.
  - Each stage carries data, dir and a valid bit.
  - Comparator: if dir=0, L=min, H=max; if dir=1, swapped. Equal keys pass through unswapped.
- Flow control:
  - adv = ~out_valid | out_ready. The whole pipeline, including launch, advances only when adv=1.
  - Bubbles are not compacted. While stalled, all stage registers and c hold their values.
- Output:
  - c and out_valid are driven directly from stage S registers.
  - c must stay stable while out_valid & ~out_ready.
- Latency: with adv held at 1, the second half loaded on edge t gives out_valid=1 after edge t+1+S. For n=4 that is 4 edges.
- Throughput: one merge per cycle when both halves are loaded every cycle and out_ready=1.
- merge_cnt increments on out_valid & out_ready and wraps modulo 2^CNT_W.
- Input halves must already be sorted in the direction given by desc. Otherwise the output order is unspecified, but it must still be a permutation of the inputs.
- Reset mid-operation: in-flight merges are discarded with no partial output, and merge_cnt returns to 0.
- A load asserted while ready[k]=0 is ignored and the held half is not modified.

Test Plan:
- WIDTH=3, n=4, desc=0: A={1,3,5,7}, B={0,2,4,6} loaded together, out_ready=1 -> out_valid exactly 4 edges later, c={0,1,2,3,4,5,6,7}, merge_cnt=1.
- desc=1: A={7,5,3,1}, B={6,4,2,0} -> c={7,6,5,4,3,2,1,0}. Also duplicates: A={2,2,5,5}, B={2,3,5,7}, desc=0 -> c={2,2,2,3,5,5,5,7}.
- Split load: A on cycle 0, B on cycle 3 -> ready[0]=0 during cycles 1..3. A second load[0] on cycle 2 is ignored. Launch occurs at the edge ending cycle 4; result is correct.
- Stall: stream 5 merges back-to-back, hold out_ready=0 for 6 cycles mid-stream -> c stable while stalled, ready drops to 0 once both halves are full, no merge lost or duplicated, merge_cnt=5.
- Reset: assert rst=0 asynchronously with 2 merges in flight -> out_valid, merge_cnt and c go to 0 immediately, and no output appears after release. Also CNT_W=2 with 5 merges -> merge_cnt wraps to 1.
- Parameter sweep: n=2, 8, 16 and WIDTH=8 with random sorted halves in both directions -> output matches a reference sort, and latency = log2(2n)+1 edges.
